// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the PUSH/POP multi-cycle stack sequencer.
package stack_seq_pkg;

  typedef enum logic [2:0] {IDLE, CALC, PRD, PWR, MRD, MWB, SPUPD} state_t;

  localparam logic [3:0] SEL_SP     = 4'hd;
  localparam logic [3:0] SEL_LR     = 4'he;
  localparam logic [3:0] SEL_PC     = 4'hf;
  localparam int         WORD_BYTES = 4;

  // Number of words moved: r0..r7 plus the optional LR/PC slot (bit 8).
  function automatic logic [3:0] slot_count(input logic [8:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) c += 4'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Lowest-set-bit encoder over the 9-slot mask (bit 8 = LR/PC slot).
module reg_list_scan (
  input  logic [8:0] mask,
  output logic [3:0] slot,
  output logic       any_left
);

  always_comb begin
    slot = '0;
    for (int i = 8; i >= 0; i--)
      if (mask[i]) slot = 4'(i);
    any_left = |mask;
  end

endmodule

// File: rtl/stack_multi_seq.sv
// Thumb PUSH/POP {reglist[,LR|PC]} sequencer: one register per two cycles, then SP commit.
module stack_multi_seq
  import stack_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_pop,
  input  logic [7:0]        reg_list,
  input  logic              r_bit,
  input  logic [31:0]       sp_cur,
  output logic [3:0]        rf_rd_select,
  input  logic [31:0]       rf_rd_data,
  output logic              rf_write_en,
  output logic [3:0]        rf_wr_select,
  output logic [31:0]       rf_wr_data,
  output logic              rf_sp_write_en,
  output logic [31:0]       rf_sp_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              pc_load_en,
  output logic [31:0]       pc_load_data,
  output logic              busy,
  output logic              done
);

  state_t      state;
  logic        pop_q;
  logic        sp_nz;
  logic [8:0]  req_mask;
  logic [8:0]  mask;
  logic [8:0]  mask_cleared;
  logic [31:0] sp_q;
  logic [31:0] addr;
  logic [31:0] new_sp;
  logic [31:0] span;
  logic [3:0]  slot;
  logic [3:0]  slot_sel;
  logic        any_left;
  logic        req_any;
  logic [3:0]  req_slot;

  reg_list_scan u_scan (
    .mask     (mask),
    .slot     (slot),
    .any_left (any_left)
  );

  // Separate scan of the request mask so CALC can pick the first state before mask is loaded.
  reg_list_scan u_req_scan (
    .mask     (req_mask),
    .slot     (req_slot),
    .any_left (req_any)
  );

  assign span         = {26'd0, slot_count(req_mask), 2'b00};
  assign mask_cleared = mask & ~(9'd1 << slot);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pop_q    <= 1'b0;
      sp_nz    <= 1'b0;
      req_mask <= '0;
      mask     <= '0;
      sp_q     <= '0;
      addr     <= '0;
      new_sp   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pop_q    <= is_pop;
          req_mask <= {r_bit, reg_list};
          sp_q     <= sp_cur;
          state    <= CALC;
        end
        CALC: begin
          mask   <= req_mask;
          sp_nz  <= req_any;
          addr   <= pop_q ? sp_q : sp_q - span;
          new_sp <= pop_q ? sp_q + span : sp_q - span;
          state  <= !req_any ? SPUPD : (pop_q ? MRD : PRD);
        end
        PRD: state <= PWR;
        MRD: state <= MWB;
        PWR, MWB: begin
          mask  <= mask_cleared;
          addr  <= addr + 32'(WORD_BYTES);
          state <= (|mask_cleared) ? (pop_q ? MRD : PRD) : SPUPD;
        end
        SPUPD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; the only input-fed outputs are the data buses, muxed by registered state.
  always_comb begin
    rf_rd_select   = '0;
    rf_write_en    = 1'b0;
    rf_wr_select   = '0;
    rf_wr_data     = '0;
    rf_sp_write_en = 1'b0;
    rf_sp_in       = '0;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    mem_re         = 1'b0;
    pc_load_en     = 1'b0;
    pc_load_data   = '0;
    done           = 1'b0;
    busy           = (state != IDLE);
    slot_sel       = (slot == 4'd8) ? (pop_q ? SEL_PC : SEL_LR) : slot;
    case (state)
      PRD: rf_rd_select = slot_sel;
      PWR: begin
        mem_we    = 1'b1;
        mem_addr  = addr[ADDR_W-1:0];
        mem_wdata = rf_rd_data;
      end
      MRD: begin
        mem_re   = 1'b1;
        mem_addr = addr[ADDR_W-1:0];
      end
      MWB: begin
        if (slot_sel == SEL_PC) begin
          pc_load_en   = 1'b1;
          pc_load_data = mem_rdata;
        end else begin
          rf_write_en  = 1'b1;
          rf_wr_select = slot_sel;
          rf_wr_data   = mem_rdata;
        end
      end
      SPUPD: begin
        rf_sp_write_en = sp_nz;
        rf_sp_in       = new_sp;
        done           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_multi_seq.sv
// Bench for stack_multi_seq: behavioural register file/memory plus a slot-list reference model.
module tb_stack_multi_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_pop, r_bit;
  logic [7:0]  reg_list;
  logic [31:0] sp_cur;
  logic [3:0]  rf_rd_select;
  logic [31:0] rf_rd_data;
  logic        rf_write_en;
  logic [3:0]  rf_wr_select;
  logic [31:0] rf_wr_data;
  logic        rf_sp_write_en;
  logic [31:0] rf_sp_in;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        pc_load_en;
  logic [31:0] pc_load_data;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] preset [$];

  pair_t       wr_q [$];
  pair_t       rfw_q [$];
  logic [31:0] pc_q [$];
  logic [31:0] sp_q [$];
  int          done_q [$];
  int          busy_cnt, rd_cnt;
  logic        last_or;

  stack_multi_seq #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .r_bit(r_bit), .sp_cur(sp_cur), .rf_rd_select(rf_rd_select), .rf_rd_data(rf_rd_data),
    .rf_write_en(rf_write_en), .rf_wr_select(rf_wr_select), .rf_wr_data(rf_wr_data),
    .rf_sp_write_en(rf_sp_write_en), .rf_sp_in(rf_sp_in), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pc_load_en(pc_load_en), .pc_load_data(pc_load_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample at negedge (record + apply writes), then advance one posedge with registered read data.
  task automatic tick(input int c);
    logic [31:0] nrd, nmr;
    @(negedge clk);
    last_or = |{rf_rd_select, rf_write_en, rf_wr_select, rf_wr_data, rf_sp_write_en, rf_sp_in,
                mem_addr, mem_we, mem_wdata, mem_re, pc_load_en, pc_load_data, busy, done};
    if (busy) busy_cnt++;
    if (done) done_q.push_back(c);
    if (mem_we) begin
      wr_q.push_back('{mem_addr, mem_wdata});
      mem[mem_addr] = mem_wdata;
    end
    if (mem_re) rd_cnt++;
    if (rf_write_en) begin
      rfw_q.push_back('{32'(rf_wr_select), rf_wr_data});
      rf[rf_wr_select] = rf_wr_data;
    end
    if (pc_load_en) pc_q.push_back(pc_load_data);
    if (rf_sp_write_en) begin
      sp_q.push_back(rf_sp_in);
      rf[13] = rf_sp_in;
    end
    nrd = rf[rf_rd_select];
    nmr = (mem_re && mem.exists(mem_addr)) ? mem[mem_addr] : 32'h0;
    @(posedge clk);
    rf_rd_data = nrd;
    mem_rdata  = nmr;
    #1;
  endtask

  task automatic clear_rec();
    wr_q.delete(); rfw_q.delete(); pc_q.delete(); sp_q.delete(); done_q.delete();
    busy_cnt = 0;
    rd_cnt   = 0;
  endtask

  task automatic run_op(input string tag, input logic pop, input logic [7:0] list,
                        input logic r, input logic [31:0] sp, input int restart_at);
    int          sl [$];
    pair_t       ew [$];
    pair_t       erw [$];
    logic [31:0] epc [$];
    logic [31:0] base, nsp, v;
    int          n;
    for (int i = 0; i < 8; i++) if (list[i]) sl.push_back(i);
    if (r) sl.push_back(pop ? 15 : 14);
    n    = sl.size();
    base = pop ? sp : sp - 32'(4 * n);
    nsp  = pop ? sp + 32'(4 * n) : sp - 32'(4 * n);
    foreach (sl[k]) begin
      if (pop) begin
        v = (preset.size() != 0) ? preset.pop_front() : $urandom;
        mem[base + 32'(4 * k)] = v;
        if (sl[k] == 15) epc.push_back(v);
        else erw.push_back('{32'(sl[k]), v});
      end else begin
        ew.push_back('{base + 32'(4 * k), rf[sl[k]]});
      end
    end
    clear_rec();
    is_pop = pop; reg_list = list; r_bit = r; sp_cur = sp; start = 1'b1;
    tick(0);
    start = 1'b0;
    for (int c = 1; c <= 2 * n + 4; c++) begin
      if (restart_at != 0 && c == restart_at) start = 1'b1;
      if (c == restart_at + 2) start = 1'b0;
      tick(c);
    end
    check({tag, " done_cnt"}, done_q.size(), 1);
    if (done_q.size() != 0) check({tag, " done_cycle"}, done_q[0], 2 * n + 2);
    check({tag, " busy_cycles"}, busy_cnt, 2 * n + 2);
    check({tag, " mem_wr_cnt"}, wr_q.size(), ew.size());
    foreach (ew[k]) if (k < wr_q.size()) begin
      check({tag, " mem_wr_addr"}, wr_q[k].a, ew[k].a);
      check({tag, " mem_wr_data"}, wr_q[k].d, ew[k].d);
    end
    check({tag, " mem_rd_cnt"}, rd_cnt, pop ? n : 0);
    check({tag, " rf_wr_cnt"}, rfw_q.size(), erw.size());
    foreach (erw[k]) if (k < rfw_q.size()) begin
      check({tag, " rf_wr_sel"}, rfw_q[k].a, erw[k].a);
      check({tag, " rf_wr_data"}, rfw_q[k].d, erw[k].d);
    end
    check({tag, " pc_cnt"}, pc_q.size(), epc.size());
    if (epc.size() != 0 && pc_q.size() != 0) check({tag, " pc_data"}, pc_q[0], epc[0]);
    check({tag, " sp_wr_cnt"}, sp_q.size(), (n != 0) ? 1 : 0);
    if (n != 0 && sp_q.size() != 0) check({tag, " sp_value"}, sp_q[0], nsp);
    check({tag, " idle_after"}, last_or, 1'b0);
  endtask

  initial begin
    logic [31:0] old2, old3, sp0;
    rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = '0; r_bit = 1'b0; sp_cur = '0;
    rf_rd_data = '0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[0] = 32'h11; rf[2] = 32'h22; rf[14] = 32'heeeeffff;
    clear_rec();
    for (int c = 0; c < 3; c++) tick(c);
    check("reset outputs", last_or, 1'b0);
    rst = 1'b0;
    tick(0);
    check("post-reset idle", last_or, 1'b0);

    run_op("push_r0_r2_lr", 1'b0, 8'b0000_0101, 1'b1, 32'h1000, 0);
    preset = '{32'ha, 32'hb, 32'h100};
    run_op("pop_r1_r7_pc", 1'b1, 8'b1000_0010, 1'b1, 32'hff4, 0);
    check("pop r1", rf[1], 32'ha);
    check("pop r7", rf[7], 32'hb);
    run_op("push_empty", 1'b0, 8'h00, 1'b0, 32'h2000, 0);
    run_op("pop_empty", 1'b1, 8'h00, 1'b0, 32'h2000, 0);
    run_op("push_all_wrap", 1'b0, 8'hff, 1'b1, 32'h10, 0);
    run_op("pop_all_wrap", 1'b1, 8'hff, 1'b1, 32'hffff_ffec, 0);
    run_op("push_restart", 1'b0, 8'b0011_1100, 1'b0, 32'h3000, 3);
    run_op("pop_pc_only", 1'b1, 8'h00, 1'b1, 32'h4000, 0);

    for (int t = 0; t < 12; t++)
      run_op("random", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom),
             $urandom & 32'hffff_fffc, 0);

    // Abort a POP {r0..r3} with reset sampled at the end of cycle 5.
    sp0  = 32'h5000;
    rf[13] = 32'h1234_5678;
    old2 = rf[2]; old3 = rf[3];
    for (int k = 0; k < 4; k++) mem[sp0 + 32'(4 * k)] = 32'hc0de_0000 + 32'(k);
    clear_rec();
    is_pop = 1'b1; reg_list = 8'h0f; r_bit = 1'b0; sp_cur = sp0; start = 1'b1;
    tick(0);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick(c);
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(6);
    check("abort outputs", last_or, 1'b0);
    check("abort r0", rf[0], 32'hc0de_0000);
    check("abort r1", rf[1], 32'hc0de_0001);
    check("abort r2", rf[2], old2);
    check("abort r3", rf[3], old3);
    check("abort sp_wr", sp_q.size(), 0);
    check("abort sp", rf[13], 32'h1234_5678);
    check("abort done", done_q.size(), 0);

    run_op("after_abort", 1'b0, 8'b1001_0001, 1'b1, 32'h6000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
